// File: rtl/rv32_pipe_stage_reg.sv
// rv32_pipe_stage_reg: handshaked inter-stage register with flush and NOP bubbles.
// Define RV32_PIPE_SKID_EN to add a 2-entry skid buffer that registers in_ready.
module rv32_pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 6,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter logic [31:0] NOP_CODE = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [31:0]       in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_code
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0]       r_code;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_from_skid;
  logic [DATA_W-1:0] w_src_data;
  logic [CTRL_W-1:0] w_src_ctrl;
  logic [31:0]       w_src_code;
  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_ctrl   = r_ctrl;
  assign out_code   = r_code;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_valid & out_ready;
`ifdef RV32_PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t            r_state;
  state_t            w_next;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [31:0]       r_skid_code;
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   w_next = w_in_fire ? ONE : EMPTY;
      ONE:     w_next = (w_in_fire & ~w_out_fire) ? TWO : (~w_in_fire & w_out_fire) ? EMPTY : ONE;
      TWO:     w_next = w_out_fire ? ONE : TWO;
      default: w_next = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != TWO);
    end
  end
  // Skid slot catches the entry accepted while the output register is stalled.
  always_ff @(posedge clk) begin
    if (w_in_fire & r_valid & ~w_out_fire) begin
      r_skid_data <= in_data;
      r_skid_ctrl <= in_ctrl;
      r_skid_code <= in_code;
    end
  end
  assign in_ready    = r_in_ready & ~rst;
  assign w_from_skid = (r_state == TWO) & w_out_fire;
  assign w_src_data  = w_from_skid ? r_skid_data : in_data;
  assign w_src_ctrl  = w_from_skid ? r_skid_ctrl : in_ctrl;
  assign w_src_code  = w_from_skid ? r_skid_code : in_code;
`else
  assign in_ready    = ~rst & (~r_valid | out_ready);
  assign w_from_skid = 1'b0;
  assign w_src_data  = in_data;
  assign w_src_ctrl  = in_ctrl;
  assign w_src_code  = in_code;
`endif
  // Bubble values live in the register itself so downstream never sees stale payload.
  always_ff @(posedge clk) begin
    if (rst | flush | (w_out_fire & ~w_from_skid & ~w_in_fire)) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= CTRL_NOP;
      r_code  <= NOP_CODE;
    end else if (w_from_skid | (w_in_fire & (~r_valid | w_out_fire))) begin
      r_valid <= 1'b1;
      r_data  <= w_src_data;
      r_ctrl  <= w_src_ctrl;
      r_code  <= w_src_code;
    end
  end
endmodule

// File: tb/tb_rv32_pipe_stage_reg.sv
// tb_rv32_pipe_stage_reg: directed table-driven bench for rv32_pipe_stage_reg.
module tb_rv32_pipe_stage_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] CA  = 32'h0010_0093;
  localparam logic [31:0] CB  = 32'h0020_0113;
  localparam logic [31:0] CC  = 32'h0030_0193;
  localparam logic [31:0] CD  = 32'h0050_0293;
  localparam logic [31:0] CE  = 32'h0060_0313;
  localparam logic [31:0] CF  = 32'h0070_0393;
  localparam logic [31:0] CG  = 32'h0080_0413;
  localparam logic [31:0] CH  = 32'h0090_0493;
  localparam logic [31:0] CK  = 32'h0040_0213;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
`ifdef RV32_PIPE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic [95:0] in_data = '1;
  logic [5:0]  in_ctrl = '1;
  logic [31:0] in_code = '1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] out_data;
  logic [5:0]  out_ctrl;
  logic [31:0] out_code;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic        iv;
    logic [31:0] c;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_c;
  } vec_t;
  vec_t tbl[10];
  rv32_pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_code(out_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [95:0] a, input logic [95:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask
  // Payload is derived from the code so data/ctrl ordering is checked alongside it.
  task automatic step(input string nm, input logic r, input logic f, input logic iv,
                      input logic [31:0] c, input logic ordy, input logic e_ir,
                      input logic e_ov, input logic [31:0] e_c);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    in_code = c; in_data = {3{c}}; in_ctrl = c[7:2];
    #1 chk({nm, ".in_ready"}, 96'(in_ready), 96'(e_ir));
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, 96'(out_valid), 96'(e_ov));
    chk({nm, ".out_code"}, 96'(out_code), 96'(e_c));
    chk({nm, ".out_data"}, out_data, e_ov ? {3{e_c}} : 96'd0);
    chk({nm, ".out_ctrl"}, 96'(out_ctrl), e_ov ? 96'(e_c[7:2]) : 96'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{H, CA, H, H, H, CA};
    tbl[1] = '{H, CB, H, H, H, CB};
    tbl[2] = '{H, CC, H, H, H, CC};
    tbl[3] = '{L, 32'd0, H, H, L, NOP};
    tbl[4] = '{H, CD, L, H, H, CD};
    if (SKID) begin
      tbl[5] = '{H, CE, L, H, H, CD};
      tbl[6] = '{H, CF, L, L, H, CD};
      tbl[7] = '{H, CF, H, L, H, CE};
    end else begin
      tbl[5] = '{H, CE, L, L, H, CD};
      tbl[6] = '{H, CE, L, L, H, CD};
      tbl[7] = '{H, CE, H, H, H, CE};
    end
    tbl[8] = '{H, CF, H, H, H, CF};
    tbl[9] = '{L, 32'd0, H, H, L, NOP};
    for (int i = 0; i < 3; i++)
      step("reset", H, L, H, 32'hFFFF_FFFF, L, L, L, NOP);
    step("release", L, L, L, 32'd0, H, H, L, NOP);
    for (int i = 0; i < 10; i++)
      step($sformatf("vec%0d", i), L, L, tbl[i].iv, tbl[i].c, tbl[i].ordy,
           tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_c);
    step("stall_load", L, L, H, CG, L, H, H, CG);
    for (int i = 0; i < 5; i++)
      step($sformatf("stall%0d", i), L, L, L, 32'h1234_0000 + i, L, SKID, H, CG);
    step("fill", L, L, H, CH, L, SKID, H, CG);
    step("flush", L, H, H, CK, L, L, L, NOP);
    step("post_flush0", L, L, L, 32'd0, H, H, L, NOP);
    step("post_flush1", L, L, L, 32'd0, H, H, L, NOP);
    step("after_flush", L, L, H, CB, H, H, H, CB);
    step("drain", L, L, L, 32'd0, H, H, L, NOP);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
